// File: rtl/button_reader.sv
// ---------------------------------------------------------------------------
// button_reader
//
// Samples up to N_BTN raw push-button pins, synchronizes and debounces them,
// and delivers clean pressed levels plus single-cycle press, release and
// long-press events to the control logic that picks LED patterns and rates.
//
// Parameters
//   CLK_FREQ     clk frequency in Hz; a 1 ms tick is derived from it
//   N_BTN        number of buttons
//   DEBOUNCE_MS  stable time (ms) required before a level change is accepted
//   LONG_MS      hold time (ms) after an accepted press that raises btn_long
//   ACTIVE_LOW   1: pressed button reads 0 on the pin, 0: pressed reads 1
//
// Ports
//   clk          system clock
//   rst_n        synchronous, active-low reset
//   btn_in       raw asynchronous button pins
//   btn_level    debounced pressed state (1 = pressed)
//   btn_press    one-cycle pulse on accepted press
//   btn_release  one-cycle pulse on accepted release
//   btn_long     one-cycle pulse when a hold reaches LONG_MS
//
// Build option
//   BUTTON_LONG_PRESS_EN  when defined, hold counters and btn_long are built;
//                         otherwise btn_long is tied to 0.
// ---------------------------------------------------------------------------
module button_reader #(
  parameter int CLK_FREQ    = 25_000_000,
  parameter int N_BTN       = 4,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  localparam int TICK_DIV = CLK_FREQ / 1000;
  localparam int PW       = $clog2(TICK_DIV);
  localparam int DW       = $clog2(DEBOUNCE_MS + 1);

  localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0]    DEB_LAST = DW'(DEBOUNCE_MS);
  localparam logic [N_BTN-1:0] PIN_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    IDLE,
    DEB_DOWN,
    PRESSED,
    DEB_UP
  } state_t;

  // Two-flop synchronizer; reset loads the released pin level so no
  // spurious press is seen when reset drops.
  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] p;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= PIN_IDLE;
      sync2 <= PIN_IDLE;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  always_comb begin
    p = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
  end

  // Shared 1 ms prescaler, free-running from reset.
  logic [PW-1:0] pre;
  logic          tick;

  always_comb begin
    tick = (pre == PRE_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

`ifndef BUTTON_LONG_PRESS_EN
  assign btn_long = '0;
`endif

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    state_t        state;
    logic [DW-1:0] dcnt;
    logic [DW-1:0] dcnt_inc;
    logic          level_q;
    logic          press_q;
    logic          rel_q;
`ifdef BUTTON_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_MS + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MS);
    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcnt_inc;
    logic          long_q;

    always_comb begin
      hcnt_inc = hcnt + HW'(1);
    end

    assign btn_long[g] = long_q;
`endif

    always_comb begin
      dcnt_inc = dcnt + DW'(1);
    end

    // A pin mismatch in the debounce states is checked before the tick, so
    // a bounce always restarts the stability window.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state   <= IDLE;
        dcnt    <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
`ifdef BUTTON_LONG_PRESS_EN
        hcnt    <= '0;
        long_q  <= 1'b0;
`endif
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
`ifdef BUTTON_LONG_PRESS_EN
        long_q  <= 1'b0;
`endif
        case (state)
          IDLE: begin
            if (p[g]) begin
              state <= DEB_DOWN;
              dcnt  <= '0;
            end
          end
          DEB_DOWN: begin
            if (!p[g]) begin
              state <= IDLE;
            end else if (tick) begin
              if (dcnt_inc == DEB_LAST) begin
                state   <= PRESSED;
                level_q <= 1'b1;
                press_q <= 1'b1;
`ifdef BUTTON_LONG_PRESS_EN
                hcnt    <= '0;
`endif
              end else begin
                dcnt <= dcnt_inc;
              end
            end
          end
          PRESSED: begin
            if (!p[g]) begin
              state <= DEB_UP;
              dcnt  <= '0;
            end
`ifdef BUTTON_LONG_PRESS_EN
            else if (tick && (hcnt != HOLD_LAST)) begin
              // Saturates at LONG_MS so btn_long fires once per press,
              // even across a bounce that returns through DEB_UP.
              hcnt <= hcnt_inc;
              if (hcnt_inc == HOLD_LAST) begin
                long_q <= 1'b1;
              end
            end
`endif
          end
          DEB_UP: begin
            if (p[g]) begin
              state <= PRESSED;
            end else if (tick) begin
              if (dcnt_inc == DEB_LAST) begin
                state   <= IDLE;
                level_q <= 1'b0;
                rel_q   <= 1'b1;
              end else begin
                dcnt <= dcnt_inc;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end

    assign btn_level[g]   = level_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = rel_q;
  end

endmodule

// File: tb/tb_button_reader.sv
module tb_button_reader;

  localparam int CLK_FREQ = 10_000;
  localparam int TD       = CLK_FREQ / 1000;
  localparam int N        = 4;
  localparam int DEB      = 3;
  localparam int LONG     = 10;
  localparam int ACT_LOW  = 1;
`ifdef BUTTON_LONG_PRESS_EN
  localparam int LONG_EXP = 1;
`else
  localparam int LONG_EXP = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_long;

  button_reader #(
    .CLK_FREQ   (CLK_FREQ),
    .N_BTN      (N),
    .DEBOUNCE_MS(DEB),
    .LONG_MS    (LONG),
    .ACTIVE_LOW (ACT_LOW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  int n_prints = 0;

  always @(posedge clk) cycle++;

  // Reference model: accepted level per button, whether the synchronized
  // input currently disagrees with it, ticks seen while disagreeing, and
  // ticks seen while held after acceptance.
  logic [N-1:0] m_s1, m_s2;
  logic [N-1:0] m_level, m_mis;
  int           m_cnt[N];
  int           m_hold[N];
  int           m_phase;
  logic [N-1:0] e_press, e_rel, e_long;
  bit           model_valid = 0;

  always @(posedge clk) begin
    logic [N-1:0] pv;
    bit tk;
    if (!rst_n) begin
      m_s1 = (ACT_LOW != 0) ? '1 : '0;
      m_s2 = m_s1;
      m_level = '0; m_mis = '0;
      e_press = '0; e_rel = '0; e_long = '0;
      m_phase = 0;
      for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_hold[i] = 0; end
      model_valid = 1;
    end else begin
      tk = ((m_phase % TD) == TD - 1);
      m_phase++;
      pv = (ACT_LOW != 0) ? ~m_s2 : m_s2;
      e_press = '0; e_rel = '0; e_long = '0;
      for (int i = 0; i < N; i++) begin
        if (pv[i] != m_level[i]) begin
          if (!m_mis[i]) begin
            m_mis[i] = 1'b1;
            m_cnt[i] = 0;
          end else if (tk) begin
            m_cnt[i]++;
            if (m_cnt[i] == DEB) begin
              m_level[i] = pv[i];
              m_mis[i] = 1'b0;
              if (pv[i]) begin e_press[i] = 1'b1; m_hold[i] = 0; end
              else e_rel[i] = 1'b1;
            end
          end
        end else begin
          if (m_mis[i]) m_mis[i] = 1'b0;
          else if (m_level[i] && tk && m_hold[i] < LONG) begin
            m_hold[i]++;
            if (m_hold[i] == LONG && LONG_EXP == 1) e_long[i] = 1'b1;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = btn_in;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      total++;
      if (btn_level !== m_level || btn_press !== e_press ||
          btn_release !== e_rel || btn_long !== e_long) begin
        bad++;
        if (n_prints < 20) begin
          n_prints++;
          $display("FAIL model_cmp cyc=%0d level=%b need %b press=%b need %b rel=%b need %b long=%b need %b",
                   cycle, btn_level, m_level, btn_press, e_press,
                   btn_release, e_rel, btn_long, e_long);
        end
      end
    end
  end

  // Event bookkeeping for the directed checks.
  int np[N], nr[N], nl[N];
  int tp[N], tr[N], tl[N];

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int b = 0; b < N; b++) begin
        if (btn_press[b] === 1'b1)   begin np[b]++; tp[b] = cycle; end
        if (btn_release[b] === 1'b1) begin nr[b]++; tr[b] = cycle; end
        if (btn_long[b] === 1'b1)    begin nl[b]++; tl[b] = cycle; end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_press(input int b, input int base);
    for (int k = 0; k < 60 && np[b] == base; k++) run(1);
  endtask

  task automatic wait_release(input int b, input int base);
    for (int k = 0; k < 60 && nr[b] == base; k++) run(1);
  endtask

  initial begin
    int t0, base, bp, bl, br;
    int dur[N];
    int ev;
    logic [15:0] outs;

    for (int i = 0; i < N; i++) begin
      np[i] = 0; nr[i] = 0; nl[i] = 0; tp[i] = 0; tr[i] = 0; tl[i] = 0;
    end
    rst_n  = 1'b0;
    btn_in = '1;
    run(3);
    outs = {btn_level, btn_press, btn_release, btn_long};
    chk("reset_outputs", int'(outs), 0);
    rst_n = 1'b1;

    // Idle with pins released: no activity at all.
    run(100);
    ev = 0;
    for (int i = 0; i < N; i++) ev += np[i] + nr[i] + nl[i];
    chk("idle_events", ev, 0);
    chk("idle_level", int'(btn_level), 0);

    // Single press on bit 0.
    base = np[0];
    btn_in[0] = 1'b0;
    t0 = cycle + 1;
    wait_press(0, base);
    chk("press0_count", np[0] - base, 1);
    chk_rng("press0_latency", tp[0] - t0, 23, 32);
    chk("press0_level", int'(btn_level[0]), 1);
    run(40);
    chk("press0_once", np[0] - base, 1);

    // Glitches on bit 1 that must be rejected.
    base = np[1];
    foreach (dur[i]) dur[i] = 0;
    for (int g = 0; g < 3; g++) begin
      btn_in[1] = 1'b0;
      run(g == 0 ? 5 : (g == 1 ? 15 : 19));
      btn_in[1] = 1'b1;
      run(25);
    end
    run(40);
    chk("glitch1_press", np[1] - base, 0);
    chk("glitch1_level", int'(btn_level[1]), 0);

    // Long hold on bit 2, then a bouncy release.
    bp = np[2]; bl = nl[2]; br = nr[2];
    btn_in[2] = 1'b0;
    run(200);
    chk("hold2_press", np[2] - bp, 1);
    chk("hold2_long_count", nl[2] - bl, LONG_EXP);
`ifdef BUTTON_LONG_PRESS_EN
    chk("hold2_long_delay", tl[2] - tp[2], 100);
`endif
    btn_in[2] = 1'b1;
    run(10);
    btn_in[2] = 1'b0;
    run(5);
    btn_in[2] = 1'b1;
    t0 = cycle + 1;
    wait_release(2, br);
    chk("rel2_count", nr[2] - br, 1);
    chk_rng("rel2_latency", tr[2] - t0, 23, 32);
    chk("rel2_level", int'(btn_level[2]), 0);
    chk("hold2_long_total", nl[2] - bl, LONG_EXP);

    // Release bit 0, then press bits 0 and 3 together.
    btn_in[0] = 1'b1;
    run(45);
    chk("all_released", int'(btn_level), 0);
    btn_in[0] = 1'b0;
    btn_in[3] = 1'b0;
    for (int k = 0; k < 60; k++) begin
      run(1);
      if (btn_press != '0) break;
    end
    chk("press_0_and_3", int'(btn_press), 9);
    run(5);
    chk("level_0_and_3", int'(btn_level), 9);

    // One-cycle reset while bit 0 is held.
    rst_n = 1'b0;
    base = np[0];
    run(1);
    outs = {btn_level, btn_press, btn_release, btn_long};
    chk("midreset_outputs", int'(outs), 0);
    rst_n = 1'b1;
    t0 = cycle + 1;
    wait_press(0, base);
    chk("repress0_count", np[0] - base, 1);
    chk_rng("repress0_latency", tp[0] - t0, 23, 32);

    // Randomized pin activity, checked cycle by cycle against the model.
    for (int i = 0; i < N; i++) dur[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < N; b++) begin
        if (dur[b] == 0) begin
          btn_in[b] = 1'(($urandom_range(0, 1)));
          dur[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8))
                                               : int'($urandom_range(20, 150));
        end else begin
          dur[b]--;
        end
      end
      rst_n = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
      run(1);
    end
    rst_n = 1'b1;
    run(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
